// File: rtl/soc_mem2_port_arbiter_pkg.sv
// Shared types and constants for the 16-bit buffer port arbiter.
package soc_mem2_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int BE_W   = DATA_W / 8;

  // IDLE: nobody holds the port; OWN0/OWN1: requester 0/1 holds it through lock.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_cmd_t;

endpackage

// File: rtl/soc_mem2_port_arbiter_if.sv
// One requester's handshake toward the buffer port arbiter.
interface soc_mem2_req_if;
  import soc_mem2_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, be,
                  input  gnt, rvalid, rdata);

  modport slave  (input  req, we, lock, addr, wdata, be,
                  output gnt, rvalid, rdata);

endinterface

// File: rtl/soc_mem2_port_arbiter_rr_pick.sv
// Two-way round-robin picker with owner preference and burst-limit yield.
module soc_mem2_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       owner_valid,
  input  logic       owner,
  input  logic       burst_exhausted,
  output logic [1:0] grant
);

  // An owner keeps the port until its burst runs out while the other side waits.
  always_comb begin
    grant = 2'b00;
    if (owner_valid) begin
      if (req[owner] && !burst_exhausted) begin
        grant[owner] = 1'b1;
      end else if (req[~owner]) begin
        grant[~owner] = 1'b1;
      end else if (req[owner]) begin
        grant[owner] = 1'b1;
      end
    end else begin
      if (req == 2'b11) begin
        grant[~last_owner] = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/soc_mem2_port_arbiter.sv
// Arbiter sharing the 16-bit buffer port between the sample writer (0)
// and the readout/DMA engine (1); one memory transaction per clock.
module soc_mem2_port_arbiter
  import soc_mem2_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  soc_mem2_req_if.slave     rq0,
  soc_mem2_req_if.slave     rq1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  arb_state_t state;
  logic       last_owner;
  logic [7:0] burst_cnt;
  logic       rvalid0_q;
  logic       rvalid1_q;

  req_cmd_t   cmd0;
  req_cmd_t   cmd1;
  req_cmd_t   cmd_g;
  logic [1:0] pick;
  logic [1:0] grant;
  logic       gnt_any;
  logic       gidx;
  logic       lock_g;
  logic       owner_valid;
  logic       owner;
  logic       owner_lock;
  logic       burst_exhausted;

  assign cmd0 = {rq0.we, rq0.addr, rq0.wdata, rq0.be};
  assign cmd1 = {rq1.we, rq1.addr, rq1.wdata, rq1.be};

  assign owner_valid     = (state != IDLE);
  assign owner           = (state == OWN1);
  assign owner_lock      = owner ? rq1.lock : rq0.lock;
  assign burst_exhausted = (burst_cnt >= MAX_B);

  soc_mem2_rr_pick u_pick (
    .req             ({rq1.req, rq0.req}),
    .last_owner      (last_owner),
    .owner_valid     (owner_valid),
    .owner           (owner),
    .burst_exhausted (burst_exhausted),
    .grant           (pick)
  );

  // Reset silences the port even if requests are already asserted.
  assign grant   = reset ? 2'b00 : pick;
  assign gnt_any = |grant;
  assign gidx    = grant[1];
  assign cmd_g   = gidx ? cmd1 : cmd0;
  assign lock_g  = gidx ? rq1.lock : rq0.lock;

  assign rq0.gnt = grant[0];
  assign rq1.gnt = grant[1];

  // Memory controls are active only in a grant cycle, so q holds its last word otherwise.
  assign mem_chipselect = gnt_any;
  assign mem_clken      = gnt_any;
  assign mem_write      = gnt_any & cmd_g.we;
  assign mem_address    = gnt_any ? cmd_g.addr  : '0;
  assign mem_writedata  = gnt_any ? cmd_g.wdata : '0;
  assign mem_byteenable = gnt_any ? cmd_g.be    : '0;

  assign rq0.rvalid = rvalid0_q;
  assign rq1.rvalid = rvalid1_q;
  assign rq0.rdata  = mem_readdata;
  assign rq1.rdata  = mem_readdata;
  assign busy       = owner_valid;

  // Ownership FSM, burst counter and one-cycle read-valid pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= 8'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      rvalid0_q <= grant[0] & ~rq0.we;
      rvalid1_q <= grant[1] & ~rq1.we;
      if (gnt_any) begin
        last_owner <= gidx;
        if (lock_g) begin
          state <= gidx ? OWN1 : OWN0;
          if (owner_valid && (owner == gidx)) begin
            if (burst_cnt < MAX_B) begin
              burst_cnt <= burst_cnt + 8'd1;
            end
          end else begin
            burst_cnt <= 8'd1;
          end
        end else begin
          state     <= IDLE;
          burst_cnt <= 8'd0;
        end
      end else if (owner_valid && !owner_lock) begin
        state     <= IDLE;
        burst_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_soc_mem2_port_arbiter.sv
// Self-checking bench for soc_mem2_port_arbiter with a behavioural buffer model
// and a read-response scoreboard.
module tb_soc_mem2_port_arbiter;
  import soc_mem2_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  soc_mem2_req_if rq0 ();
  soc_mem2_req_if rq1 ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic              busy;

  soc_mem2_port_arbiter #(.MAX_BURST(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .rq0            (rq0),
    .rq1            (rq1),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
  );

  logic [DATA_W-1:0] mem_arr [2048];
  logic [DATA_W-1:0] ref_mem [2048];
  logic [ADDR_W-1:0] addr_q = '0;

  // Buffer model: registered address, unregistered q, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        if (mem_byteenable[0]) mem_arr[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) mem_arr[mem_address][15:8] <= mem_writedata[15:8];
      end
      addr_q <= mem_address;
    end
  end
  assign mem_readdata = mem_arr[addr_q];

  typedef struct {
    int                idx;
    logic [DATA_W-1:0] data;
    int                due;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  sb_en  = 1'b0;

  // Cycle counter used to time expected read responses.
  always @(posedge clk) cyc <= cyc + 1;

  bit                mon_ev0;
  bit                mon_ev1;
  logic [DATA_W-1:0] mon_ed;
  sb_t               mon_e;

  // Scoreboard: every cycle, rvalid must match exactly what is due.
  always @(negedge clk) begin
    if (sb_en) begin
      mon_ev0 = 1'b0;
      mon_ev1 = 1'b0;
      mon_ed  = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_e  = sbq.pop_front();
        mon_ed = mon_e.data;
        if (mon_e.idx == 0) mon_ev0 = 1'b1;
        else                mon_ev1 = 1'b1;
      end
      checks++;
      if (rq0.rvalid !== mon_ev0 || rq1.rvalid !== mon_ev1) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got=%b%b exp=%b%b", cyc, rq1.rvalid, rq0.rvalid, mon_ev1, mon_ev0);
      end
      if (mon_ev0) begin
        checks++;
        if (rq0.rdata !== mon_ed) begin
          errors++;
          $display("FAIL rdata0 cyc=%0d got=%h exp=%h", cyc, rq0.rdata, mon_ed);
        end
      end
      if (mon_ev1) begin
        checks++;
        if (rq1.rdata !== mon_ed) begin
          errors++;
          $display("FAIL rdata1 cyc=%0d got=%h exp=%h", cyc, rq1.rdata, mon_ed);
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] pat(int a);
    return 16'((a * 263) ^ 23130);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq0.req = 0; rq0.we = 0; rq0.lock = 0; rq0.addr = '0; rq0.wdata = '0; rq0.be = '0;
    rq1.req = 0; rq1.we = 0; rq1.lock = 0; rq1.addr = '0; rq1.wdata = '0; rq1.be = '0;
  endtask

  task automatic push_read(int idx, logic [ADDR_W-1:0] a);
    sb_t e;
    e.idx  = idx;
    e.data = ref_mem[a];
    e.due  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    rq0.req = 1; rq0.addr = 11'h2AA; rq0.wdata = 16'h1234; rq0.be = 2'b11;
    rq1.req = 1; rq1.addr = 11'h155; rq1.wdata = 16'h8001; rq1.be = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got=%b exp=00", {rq1.gnt, rq0.gnt});
    end
    checks++;
    if ({mem_chipselect, mem_clken, mem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_mem_ctrl got=%b exp=000", {mem_chipselect, mem_clken, mem_write});
    end
    checks++;
    if (mem_address !== '0 || mem_writedata !== '0 || mem_byteenable !== '0) begin
      errors++; $display("FAIL reset_mem_bus got=%h/%h/%b exp=0", mem_address, mem_writedata, mem_byteenable);
    end
    checks++;
    if ({busy, rq1.rvalid, rq0.rvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b exp=000", {busy, rq1.rvalid, rq0.rvalid});
    end
    step();
    reset = 1'b0;
    idle_inputs();
    sb_en = 1'b1;
    step();
  endtask

  task automatic test_rr_alternate();
    bit e0;
    do_reset();
    rq0.req = 1; rq0.addr = 11'h005;
    rq1.req = 1; rq1.addr = 11'h7FF;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      @(negedge clk);
      e0 = (k % 2 == 1);
      checks++;
      if ({rq1.gnt, rq0.gnt} !== (e0 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, {rq1.gnt, rq0.gnt}, e0 ? 2'b01 : 2'b10);
      end
      checks++;
      if (mem_address !== (e0 ? 11'h005 : 11'h7FF) || {mem_chipselect, mem_clken, mem_write} !== 3'b110) begin
        errors++; $display("FAIL rr_mem k=%0d got=%h/%b", k, mem_address, {mem_chipselect, mem_clken, mem_write});
      end
      if (e0) push_read(0, 11'h005);
      else    push_read(1, 11'h7FF);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] exp_w;
    rq0.req = 1; rq0.we = 1; rq0.addr = 11'h010; rq0.wdata = 16'hA5C3; rq0.be = 2'b01;
    @(negedge clk);
    checks++;
    if (rq0.gnt !== 1'b1 || mem_write !== 1'b1 || mem_address !== 11'h010 ||
        mem_writedata !== 16'hA5C3 || mem_byteenable !== 2'b01) begin
      errors++; $display("FAIL wr_grant got gnt=%b we=%b a=%h d=%h be=%b", rq0.gnt, mem_write,
                         mem_address, mem_writedata, mem_byteenable);
    end
    exp_w = {ref_mem[11'h010][15:8], 8'hC3};
    ref_mem[11'h010] = exp_w;
    step();
    rq0.we = 0;
    @(negedge clk);
    checks++;
    if (rq0.gnt !== 1'b1 || mem_write !== 1'b0 || mem_chipselect !== 1'b1) begin
      errors++; $display("FAIL rd_after_wr got gnt=%b we=%b cs=%b exp=1/0/1", rq0.gnt, mem_write, mem_chipselect);
    end
    push_read(0, 11'h010);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL wr_idle got we=%b cs=%b exp=0/0", mem_write, mem_chipselect);
    end
    step();
  endtask

  task automatic test_burst_lock();
    do_reset();
    rq0.req = 1; rq0.lock = 1; rq0.addr = 11'h020;
    rq1.req = 1; rq1.addr = 11'h030;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) step();
      @(negedge clk);
      checks++;
      if ({rq1.gnt, rq0.gnt} !== (i < 8 ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL burst_gnt i=%0d got=%b exp=%b", i, {rq1.gnt, rq0.gnt}, i < 8 ? 2'b01 : 2'b10);
      end
      checks++;
      if (busy !== (i > 0)) begin
        errors++; $display("FAIL burst_busy i=%0d got=%b exp=%b", i, busy, i > 0);
      end
      if (i < 8) push_read(0, 11'h020);
      else       push_read(1, 11'h030);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL burst_release got busy=%b exp=0", busy);
    end
    step();
  endtask

  task automatic test_no_rotation();
    do_reset();
    rq0.req = 1; rq0.lock = 1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      rq0.addr = 11'h100 + 11'(i);
      @(negedge clk);
      checks++;
      if ({rq1.gnt, rq0.gnt} !== 2'b01) begin
        errors++; $display("FAIL solo_gnt i=%0d got=%b exp=01", i, {rq1.gnt, rq0.gnt});
      end
      push_read(0, rq0.addr);
    end
    step();
    rq0.req = 0;
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b00 || busy !== 1'b1) begin
      errors++; $display("FAIL hold_own got gnt=%b busy=%b exp=00/1", {rq1.gnt, rq0.gnt}, busy);
    end
    step();
    rq0.req = 1;
    rq1.req = 1; rq1.addr = 11'h030;
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b10) begin
      errors++; $display("FAIL sat_rotate got=%b exp=10", {rq1.gnt, rq0.gnt});
    end
    push_read(1, 11'h030);
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rotate_idle got busy=%b exp=0", busy);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    rq1.req = 1; rq1.addr = 11'h040;
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b10) begin
      errors++; $display("FAIL midrd_gnt got=%b exp=10", {rq1.gnt, rq0.gnt});
    end
    sb_en = 1'b0;
    step();
    reset = 1'b1;
    rq0.req = 1; rq0.addr = 11'h2AA; rq0.wdata = 16'hFFFF; rq0.be = 2'b11;
    rq1.req = 1; rq1.addr = 11'h155;
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt, mem_chipselect, mem_clken, mem_write} !== 5'b00000) begin
      errors++; $display("FAIL midrd_ctrl got=%b exp=00000", {rq1.gnt, rq0.gnt, mem_chipselect, mem_clken, mem_write});
    end
    checks++;
    if (mem_address !== '0 || mem_writedata !== '0 || mem_byteenable !== '0) begin
      errors++; $display("FAIL midrd_bus got=%h/%h/%b exp=0", mem_address, mem_writedata, mem_byteenable);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rq1.rvalid, rq0.rvalid, busy} !== 3'b000) begin
      errors++; $display("FAIL midrd_drop got=%b exp=000", {rq1.rvalid, rq0.rvalid, busy});
    end
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b01) begin
      errors++; $display("FAIL midrd_first got=%b exp=01", {rq1.gnt, rq0.gnt});
    end
    step();
    idle_inputs();
    step();
    sb_en = 1'b1;
  endtask

  task automatic test_idle_gap();
    rq1.req = 1; rq1.addr = 11'h123;
    @(negedge clk);
    checks++;
    if ({rq1.gnt, rq0.gnt} !== 2'b10) begin
      errors++; $display("FAIL gap_gnt got=%b exp=10", {rq1.gnt, rq0.gnt});
    end
    push_read(1, 11'h123);
    step();
    idle_inputs();
    rq0.addr = 11'h456;
    rq1.addr = 11'h321;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      @(negedge clk);
      checks++;
      if (mem_clken !== 1'b0 || mem_chipselect !== 1'b0) begin
        errors++; $display("FAIL gap_ctrl i=%0d got clken=%b cs=%b exp=0/0", i, mem_clken, mem_chipselect);
      end
      checks++;
      if (mem_readdata !== ref_mem[11'h123]) begin
        errors++; $display("FAIL gap_q i=%0d got=%h exp=%h", i, mem_readdata, ref_mem[11'h123]);
      end
    end
    step();
  endtask

  task automatic test_drain();
    repeat (3) step();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_drain got=%0d pending exp=0", sbq.size());
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      mem_arr[a] = pat(a);
      ref_mem[a] = pat(a);
    end
    test_reset();
    test_rr_alternate();
    test_write_read();
    test_burst_lock();
    test_no_rotation();
    test_reset_mid_read();
    test_idle_gap();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
